ibex_mult_pext_seq: RTL
=======================

Name: ibex_mult_pext_seq

Overview:
- Sequencer FSM for the shared P-ext/M-ext multiplier datapath.
- Takes the per-op cycle code produced by the multiplier decode helper and steps the multiplier through its partial-product phases and the optional ALU-accumulate phase.
- Holds the intermediate partial result between phases and signals completion to the ID/EX stage.
- Sits between the decode helper and the multiplier/ALU datapath inside the EX block.

Parameters:
- IMD_W, 34, width of the intermediate partial-result register.

Ports:
- clk_i  input  1  core clock
- rst_ni  input  1  asynchronous active-low reset
- mult_en_i  input  1  op request; held high by ID until valid_o
- cycle_code_i  input  2  00=1 mult; 01=2 mult; 10=1 mult+accum; 11=2 mult+accum
- kill_i  input  1  flush; aborts the op in flight
- partial_i  input  IMD_W  multiplier partial result for the current phase
- mult_phase_o  output  2  0=low phase, 1=high phase, 2=accumulate
- mult_active_o  output  1  multiplier array in use this cycle
- accum_en_o  output  1  ALU performs rd +/- result this cycle
- partial_o  output  IMD_W  registered intermediate from the previous phase
- busy_o  output  1  op in flight beyond its first cycle
- valid_o  output  1  result valid this cycle; ID may retire

Behaviour:
- Single clock, clk_i. Reset is asynchronous, active-low on rst_ni.
- Reset values:
  - state = ST_P0
  - code_q = 2'b00
  - partial_q = 0
- All outputs are combinational from state and inputs. With mult_en_i low in ST_P0, every output is 0 except partial_o = partial_q.
- code_q is latched from cycle_code_i on the first cycle of an op (ST_P0 & mult_en_i & ~kill_i). Later phases use code_q only, so mid-op changes to cycle_code_i are ignored.

States:
- ST_P0 (idle/first phase). When mult_en_i & ~kill_i:
  - mult_phase_o = 0, mult_active_o = 1.
  - Code 00: valid_o = 1; stay in ST_P0.
  - Code 01 or 11: capture partial_q <= partial_i; next state ST_P1.
  - Code 10: capture partial_q <= partial_i; next state ST_ACC.
- ST_P1:
  - mult_phase_o = 1, mult_active_o = 1, busy_o = 1.
  - If code_q[1]: capture partial_q <= partial_i; next state ST_ACC.
  - Else: valid_o = 1; next state ST_P0.
- ST_ACC:
  - mult_phase_o = 2, accum_en_o = 1, mult_active_o = 0, busy_o = 1, valid_o = 1.
  - Next state ST_P0.

Latency (cycles from first mult_en_i to valid_o, inclusive):
- code 00 = 1
- code 01 = 2
- code 10 = 2
- code 11 = 3

Boundary conditions:
- kill_i in any state: next state ST_P0; valid_o, accum_en_o and mult_active_o are forced 0 that cycle; partial_q is not updated.
- kill_i has priority over mult_en_i.
- mult_en_i deasserted while in ST_P1 or ST_ACC: treated as an abort (same as kill_i), with no valid_o.
- Back-to-back ops: after valid_o from ST_P1 or ST_ACC, a new op may start on the very next cycle in ST_P0.
- A code-00 op may issue every cycle.
- Async reset mid-op: state returns to ST_P0 immediately; no valid_o follows.
- partial_q holds its value whenever it is not being captured. partial_o is stale while idle; consumers must not rely on it then.

Test Plan:
- Code 00, mult_en_i high for 3 cycles -> valid_o = 1 every cycle, mult_phase_o = 0, busy_o never 1.
- Code 01, partial_i = 34'h1_2345_6789 in cycle 0 -> cycle 1: mult_phase_o = 1, partial_o = 34'h1_2345_6789, valid_o = 1; cycle 2 back in ST_P0.
- Code 11, partial_i = 34'h3 in cycle 0, then 34'h7 in cycle 1 -> cycle 2: accum_en_o = 1, mult_phase_o = 2, partial_o = 34'h7, valid_o = 1.
- Code 10 with cycle_code_i switched to 00 in cycle 1 -> ST_ACC is still entered, valid_o asserts in cycle 1 only (latched code 10 honoured).
- Code 11 with kill_i in cycle 1 -> no valid_o, state returns to ST_P0 in cycle 2, partial_q keeps its cycle-0 value; a new code-00 op in cycle 2 completes in cycle 2.
- rst_ni pulled low in ST_ACC -> state = ST_P0 and partial_q = 0 with no clock edge; all outputs 0 while mult_en_i = 0.

Source files
------------

// File: rtl/ibex_mult_pext_seq.sv
// Sequencer for the shared P-ext/M-ext multiplier: walks the low/high partial-product
// phases and the optional ALU-accumulate phase, holding the intermediate between phases.
module ibex_mult_pext_seq #(
    parameter int IMD_W = 34
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             mult_en_i,
    input  logic [1:0]       cycle_code_i,
    input  logic             kill_i,
    input  logic [IMD_W-1:0] partial_i,
    output logic [1:0]       mult_phase_o,
    output logic             mult_active_o,
    output logic             accum_en_o,
    output logic [IMD_W-1:0] partial_o,
    output logic             busy_o,
    output logic             valid_o
);

    // state  | meaning
    // ST_P0  | idle, or first (low) multiply phase of a new op
    // ST_P1  | second (high) multiply phase
    // ST_ACC | ALU accumulate of rd +/- product
    typedef enum logic [1:0] {
        ST_P0  = 2'd0,
        ST_P1  = 2'd1,
        ST_ACC = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       code_q, code_d;
    logic [IMD_W-1:0] partial_q, partial_d;
    logic             abort;

    // In later phases a dropped request is handled exactly like a flush.
    assign abort = kill_i | ~mult_en_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_P0;
            code_q    <= 2'b00;
            partial_q <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            partial_q <= partial_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        code_d        = code_q;
        partial_d     = partial_q;
        mult_phase_o  = 2'd0;
        mult_active_o = 1'b0;
        accum_en_o    = 1'b0;
        busy_o        = 1'b0;
        valid_o       = 1'b0;

        unique case (state_q)
            ST_P0: begin
                if (mult_en_i && !kill_i) begin
                    mult_active_o = 1'b1;
                    code_d        = cycle_code_i;
                    unique case (cycle_code_i)
                        2'b00: valid_o = 1'b1;
                        2'b10: begin
                            partial_d = partial_i;
                            state_d   = ST_ACC;
                        end
                        default: begin
                            partial_d = partial_i;
                            state_d   = ST_P1;
                        end
                    endcase
                end
            end
            ST_P1: begin
                mult_phase_o = 2'd1;
                busy_o       = 1'b1;
                if (abort) begin
                    state_d = ST_P0;
                end else begin
                    mult_active_o = 1'b1;
                    if (code_q[1]) begin
                        partial_d = partial_i;
                        state_d   = ST_ACC;
                    end else begin
                        valid_o = 1'b1;
                        state_d = ST_P0;
                    end
                end
            end
            ST_ACC: begin
                mult_phase_o = 2'd2;
                busy_o       = 1'b1;
                state_d      = ST_P0;
                if (!abort) begin
                    accum_en_o = 1'b1;
                    valid_o    = 1'b1;
                end
            end
            default: state_d = ST_P0;
        endcase
    end

    assign partial_o = partial_q;

endmodule
